// File: rtl/common_pkg.sv
// Shared definitions for the system bus side of the board.
//   WB_ADDR_WIDTH / DATA_WIDTH : Wishbone peripheral port geometry
//   SYS_CLOCK_MHZ              : system clock frequency
//   spi_wb_state_t             : state encoding of the SPI-to-Wishbone bridge
//   SPI_CMD_*                  : command byte field positions for the bridge
package common_pkg;

  localparam int WB_ADDR_WIDTH = 17;
  localparam int DATA_WIDTH    = 8;
  localparam int SYS_CLOCK_MHZ = 64;

  typedef enum logic [2:0] {
    CMD,
    ADDR_HI,
    ADDR_LO,
    DATA,
    REQ,
    ACK,
    XFER,
    IGNORE
  } spi_wb_state_t;

  localparam int         SPI_CMD_WE_BIT    = 7;
  localparam int         SPI_CMD_A16_BIT   = 0;
  localparam logic [7:0] SPI_CMD_RSVD_MASK = 8'h7E;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchronizer for an asynchronous input with registered edge pulses.
//   clk, rst : system clock, synchronous active-high reset
//   d_i      : asynchronous input
//   q_o      : synchronized level (SYNC_STAGES flops after d_i)
//   rise_o   : one-cycle pulse, registered, after q_o goes 0->1
//   fall_o   : one-cycle pulse, registered, after q_o goes 1->0
module sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   prev_q, prev_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  always_comb begin
    sync_d[0] = d_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
    prev_d = sync_q[SYNC_STAGES-1];
    rise_d = sync_q[SYNC_STAGES-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_STAGES-1] & prev_q;
  end

  // Reset to the idle level so leaving reset does not fake an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      prev_q <= RST_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign q_o    = sync_q[SYNC_STAGES-1];
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 target that turns byte-framed MCU commands into single-beat
// Wishbone B4 pipelined master transactions with address auto-increment.
//   wb_clock_i, wb_reset_i : system clock, synchronous active-high reset
//   spi_cs_ni, spi_sck_i, spi_sd_i : asynchronous SPI inputs (CS low active)
//   spi_sd_o    : MISO, read data MSB first
//   spi_stall_o : high while a Wishbone transaction is outstanding
//   wb_*        : Wishbone master port (addr, wdata, we, cyc, stb, stall, ack, rdata)
module spi_wb_bridge
  import common_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                     wb_clock_i,
  input  logic                     wb_reset_i,
  input  logic                     spi_cs_ni,
  input  logic                     spi_sck_i,
  input  logic                     spi_sd_i,
  output logic                     spi_sd_o,
  output logic                     spi_stall_o,
  output logic [WB_ADDR_WIDTH-1:0] wb_addr_o,
  output logic [DATA_WIDTH-1:0]    wb_data_o,
  input  logic [DATA_WIDTH-1:0]    wb_data_i,
  output logic                     wb_we_o,
  output logic                     wb_cycle_o,
  output logic                     wb_strobe_o,
  input  logic                     wb_stall_i,
  input  logic                     wb_ack_i
);

  logic sck_s, sck_rise, sck_fall;
  logic cs_s, cs_rise, cs_fall;
  logic unused_edges;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .clk(wb_clock_i), .rst(wb_reset_i), .d_i(spi_sck_i),
    .q_o(sck_s), .rise_o(sck_rise), .fall_o(sck_fall)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
    .clk(wb_clock_i), .rst(wb_reset_i), .d_i(spi_cs_ni),
    .q_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
  );

  assign unused_edges = ^{sck_s, cs_rise, cs_fall};

  // MOSI only needs the level; same depth as sck so it lines up with sck_rise.
  logic [SYNC_STAGES-1:0] sd_sync_q, sd_sync_d;
  logic                   sd_s;

  always_comb begin
    sd_sync_d[0] = spi_sd_i;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sd_sync_d[i] = sd_sync_q[i-1];
    end
  end
  assign sd_s = sd_sync_q[SYNC_STAGES-1];

  spi_wb_state_t            state_q, state_d;
  logic [2:0]               bit_cnt_q, bit_cnt_d;
  logic [6:0]               rx_q, rx_d;
  logic [7:0]               tx_q, tx_d;
  logic [WB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    dat_q, dat_d;
  logic                     we_q, we_d;
  logic                     cyc_q, cyc_d;
  logic                     stb_q, stb_d;
  logic                     stall_q, stall_d;
  logic                     abort_q, abort_d;

  logic [7:0] rx_byte;
  logic       byte_done;
  logic       launch;

  assign rx_byte   = {rx_q, sd_s};
  assign byte_done = sck_rise && !cs_s && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    dat_d     = dat_q;
    we_d      = we_q;
    cyc_d     = cyc_q;
    stb_d     = stb_q;
    stall_d   = stall_q;
    abort_d   = abort_q;
    launch    = 1'b0;

    if (cs_s) begin
      bit_cnt_d = 3'd0;
    end else if (sck_rise) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
      rx_d      = rx_byte[6:0];
    end

    // The 8th fall of a byte (counter already wrapped to 0) must not shift:
    // a prefetch ack may have reloaded tx_q just before it.
    if (sck_fall && (bit_cnt_q != 3'd0)) begin
      tx_d = {tx_q[6:0], 1'b0};
    end

    case (state_q)
      CMD: begin
        if (byte_done) begin
          if ((rx_byte & SPI_CMD_RSVD_MASK) != 8'h00) begin
            state_d = IGNORE;
          end else begin
            we_d       = rx_byte[SPI_CMD_WE_BIT];
            addr_d[16] = rx_byte[SPI_CMD_A16_BIT];
            state_d    = ADDR_HI;
          end
        end
      end
      ADDR_HI: begin
        if (byte_done) begin
          addr_d[15:8] = rx_byte;
          state_d      = ADDR_LO;
        end
      end
      ADDR_LO: begin
        if (byte_done) begin
          addr_d[7:0] = rx_byte;
          if (we_q) state_d = DATA;
          else      launch  = 1'b1;
        end
      end
      DATA: begin
        if (byte_done) begin
          dat_d  = rx_byte;
          launch = 1'b1;
        end
      end
      XFER: begin
        if (byte_done) launch = 1'b1;
      end
      REQ: begin
        if (cs_s) abort_d = 1'b1;
        if (!wb_stall_i) begin
          stb_d   = 1'b0;
          state_d = ACK;
        end
      end
      ACK: begin
        if (cs_s) abort_d = 1'b1;
        if (wb_ack_i) begin
          cyc_d   = 1'b0;
          stall_d = 1'b0;
          abort_d = 1'b0;
          addr_d  = addr_q + 17'd1;
          if (abort_q || cs_s) begin
            state_d = CMD;
          end else if (we_q) begin
            state_d = DATA;
          end else begin
            tx_d    = wb_data_i;
            state_d = XFER;
          end
        end
      end
      default: ;
    endcase

    if (launch) begin
      cyc_d   = 1'b1;
      stb_d   = 1'b1;
      stall_d = 1'b1;
      state_d = REQ;
    end

    // Deselect ends the frame, except that an issued cycle always runs to ack.
    if (cs_s && (state_q != REQ) && (state_q != ACK)) begin
      state_d = CMD;
    end
  end

  always_ff @(posedge wb_clock_i) begin
    if (wb_reset_i) begin
      sd_sync_q <= '0;
      state_q   <= CMD;
      bit_cnt_q <= 3'd0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      dat_q     <= '0;
      we_q      <= 1'b0;
      cyc_q     <= 1'b0;
      stb_q     <= 1'b0;
      stall_q   <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      sd_sync_q <= sd_sync_d;
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      dat_q     <= dat_d;
      we_q      <= we_d;
      cyc_q     <= cyc_d;
      stb_q     <= stb_d;
      stall_q   <= stall_d;
      abort_q   <= abort_d;
    end
  end

  assign spi_sd_o    = tx_q[7];
  assign spi_stall_o = stall_q;
  assign wb_addr_o   = addr_q;
  assign wb_data_o   = dat_q;
  assign wb_we_o     = we_q;
  assign wb_cycle_o  = cyc_q;
  assign wb_strobe_o = stb_q;

endmodule

// File: tb/tb_spi_wb_bridge.sv
// Bench for spi_wb_bridge: SPI master driver, Wishbone slave RAM model,
// transaction scoreboard and MISO expectation queue.
module tb_spi_wb_bridge;

  localparam int SS = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cs_n = 1'b1;
  logic        sck = 1'b0;
  logic        sdi = 1'b0;
  logic        sdo;
  logic        stall_o;
  logic [16:0] addr;
  logic [7:0]  dat_o;
  logic [7:0]  dat_i = 8'h00;
  logic        we;
  logic        cyc;
  logic        stb;
  logic        stall_i = 1'b0;
  logic        ack_i = 1'b0;

  spi_wb_bridge #(.SYNC_STAGES(SS)) dut (
    .wb_clock_i (clk),
    .wb_reset_i (rst),
    .spi_cs_ni  (cs_n),
    .spi_sck_i  (sck),
    .spi_sd_i   (sdi),
    .spi_sd_o   (sdo),
    .spi_stall_o(stall_o),
    .wb_addr_o  (addr),
    .wb_data_o  (dat_o),
    .wb_data_i  (dat_i),
    .wb_we_o    (we),
    .wb_cycle_o (cyc),
    .wb_strobe_o(stb),
    .wb_stall_i (stall_i),
    .wb_ack_i   (ack_i)
  );

  always #8 clk = ~clk;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [16:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       exp_q[$];
  logic [7:0] miso_q[$];
  logic [7:0] mem[int];

  // Slave model knobs and observations.
  int          stall_left = 0;
  int          ack_delay = 0;
  int          ack_cnt = -1;
  int          n_txn = 0;
  int          n_cyc_rise = 0;
  int          cyc_rise_cnt = 0;
  int          stb_cycles = 0;
  int          unstable = 0;
  int          stall_bad = 0;
  int          last_rise = 0;
  logic        prev_cyc = 1'b0;
  logic [16:0] hold_addr = '0;
  logic        hold_we = 1'b0;
  logic [7:0]  hold_dat = '0;

  task automatic exp_txn(input logic w, input logic [16:0] a, input logic [7:0] d);
    txn_t t;
    t.we = w; t.addr = a; t.data = d;
    exp_q.push_back(t);
  endtask

  // Wishbone slave: acts mid-cycle so DUT outputs are stable and its inputs
  // are settled before the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      ack_i = 1'b0;
      if (ack_cnt == 0) begin
        ack_i   = 1'b1;
        ack_cnt = -1;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
      end
      if (!rst) begin
        if (cyc && !prev_cyc) begin
          cyc_rise_cnt = cyc_cnt;
          n_cyc_rise++;
          hold_addr = addr; hold_we = we; hold_dat = dat_o;
        end
        if (cyc && (addr !== hold_addr || we !== hold_we || dat_o !== hold_dat)) unstable++;
        if (cyc !== stall_o) stall_bad++;
        if (stb) begin
          stb_cycles++;
          if (stall_left > 0) begin
            stall_i = 1'b1;
            stall_left--;
          end else begin
            stall_i = 1'b0;
            n_txn++;
            if (exp_q.size() == 0) begin
              chk("txn_unexpected", {15'd0, addr}, 32'hFFFF_FFFF);
            end else begin
              txn_t e;
              e = exp_q.pop_front();
              chk("txn_addr", {15'd0, addr}, {15'd0, e.addr});
              chk("txn_we", {31'd0, we}, {31'd0, e.we});
              if (e.we) chk("txn_data", {24'd0, dat_o}, {24'd0, e.data});
            end
            if (we) mem[int'(addr)] = dat_o;
            else    dat_i = mem.exists(int'(addr)) ? mem[int'(addr)] : 8'h00;
            ack_cnt = ack_delay;
          end
        end else begin
          stall_i = 1'b0;
        end
      end
      prev_cyc = cyc;
    end
  end

  task automatic wait_stall_low();
    int t = 0;
    while (stall_o === 1'b1 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("stall_timeout", {31'd0, stall_o}, 32'd0);
  endtask

  task automatic wait_ack_state();
    int t = 0;
    while (!(cyc === 1'b1 && stb === 1'b0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("ack_state_timeout", {31'd0, cyc}, 32'd1);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
    wait_stall_low();
    rx = 8'h00;
    for (int i = 7; i > 7 - n; i--) begin
      @(negedge clk);
      sdi = b[i];
      repeat (6) @(negedge clk);
      rx[i]     = sdo;
      sck       = 1'b1;
      last_rise = cyc_cnt;
      repeat (6) @(negedge clk);
      sck = 1'b0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    logic [7:0] r;
    spi_bits(b, 8, r);
  endtask

  task automatic cs_low();
    @(negedge clk);
    cs_n = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic cs_high();
    wait_stall_low();
    @(negedge clk);
    cs_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_sdo"},   {31'd0, sdo},     32'd0);
    chk({tag, "_stall"}, {31'd0, stall_o}, 32'd0);
    chk({tag, "_addr"},  {15'd0, addr},    32'd0);
    chk({tag, "_dat"},   {24'd0, dat_o},   32'd0);
    chk({tag, "_we"},    {31'd0, we},      32'd0);
    chk({tag, "_cyc"},   {31'd0, cyc},     32'd0);
    chk({tag, "_stb"},   {31'd0, stb},     32'd0);
  endtask

  initial begin
    #(16 * 60000);
    $display("FAIL watchdog cycles=%0d exp=done", cyc_cnt);
    $fatal(1, "watchdog");
  end

  initial begin
    int         n0;
    int         c0;
    logic [7:0] r;

    repeat (4) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Single write 80 80 00 5A
    exp_txn(1'b1, 17'h08000, 8'h5A);
    n0 = n_txn;
    cs_low();
    send(8'h80); send(8'h80); send(8'h00); send(8'h5A);
    chk("w1_latency", cyc_rise_cnt - last_rise, SS + 2);
    cs_high();
    chk("w1_count", n_txn - n0, 1);
    chk("w1_mem", {24'd0, mem[int'(17'h08000)]}, 32'h5A);

    // Burst read across the 17-bit wrap, with prefetch of 0x00001
    mem[int'(17'h1FFFF)] = 8'hA5;
    mem[0] = 8'h3C;
    mem[1] = 8'h77;
    exp_txn(1'b0, 17'h1FFFF, 8'h00);
    exp_txn(1'b0, 17'h00000, 8'h00);
    exp_txn(1'b0, 17'h00001, 8'h00);
    n0 = n_txn;
    cs_low();
    send(8'h01); send(8'hFF); send(8'hFF);
    miso_q.push_back(8'hA5);
    miso_q.push_back(8'h3C);
    for (int k = 0; k < 2; k++) begin
      spi_bits(8'h00, 8, r);
      chk("rd_miso", {24'd0, r}, {24'd0, miso_q.pop_front()});
    end
    cs_high();
    chk("rd_count", n_txn - n0, 3);

    // Write with 40 stalled cycles
    stall_left = 40;
    stb_cycles = 0;
    unstable   = 0;
    exp_txn(1'b1, 17'h00123, 8'hC3);
    n0 = n_txn;
    cs_low();
    send(8'h80); send(8'h01); send(8'h23); send(8'hC3);
    cs_high();
    chk("stall_stb_cycles", stb_cycles, 41);
    chk("stall_count", n_txn - n0, 1);
    chk("stall_addr_stable", unstable, 0);

    // Reserved command bits: frame ignored, next frame works
    c0 = n_cyc_rise;
    cs_low();
    send(8'h40); send(8'h12); send(8'h34); send(8'h56);
    cs_high();
    chk("rsvd_no_cyc", n_cyc_rise - c0, 0);
    exp_txn(1'b1, 17'h00010, 8'h11);
    cs_low();
    send(8'h80); send(8'h00); send(8'h10); send(8'h11);
    cs_high();
    chk("rsvd_next_mem", {24'd0, mem[int'(17'h00010)]}, 32'h11);

    // Deselect after 5 bits of a data byte
    c0 = n_cyc_rise;
    cs_low();
    send(8'h80); send(8'h00); send(8'h20);
    spi_bits(8'hEE, 5, r);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("abort_bits_no_cyc", n_cyc_rise - c0, 0);

    // Deselect while waiting for ack
    ack_delay = 10;
    exp_txn(1'b1, 17'h00030, 8'h77);
    n0 = n_txn;
    cs_low();
    send(8'h80); send(8'h00); send(8'h30); send(8'h77);
    wait_ack_state();
    @(negedge clk);
    cs_n = 1'b1;
    wait_stall_low();
    repeat (10) @(negedge clk);
    chk("abort_ack_count", n_txn - n0, 1);
    chk("abort_ack_cyc", {31'd0, cyc}, 32'd0);
    ack_delay = 0;
    exp_txn(1'b1, 17'h00031, 8'h22);
    n0 = n_txn;
    cs_low();
    send(8'h80); send(8'h00); send(8'h31); send(8'h22);
    cs_high();
    chk("after_abort_count", n_txn - n0, 1);
    chk("after_abort_mem", {24'd0, mem[int'(17'h00031)]}, 32'h22);

    // Reset while in ACK, then a fresh write
    ack_delay = 1000;
    exp_txn(1'b1, 17'h00040, 8'h99);
    cs_low();
    send(8'h80); send(8'h00); send(8'h40); send(8'h99);
    wait_ack_state();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("rst_ack");
    rst       = 1'b0;
    ack_cnt   = -1;
    ack_delay = 0;
    cs_n      = 1'b1;
    repeat (8) @(negedge clk);
    exp_txn(1'b1, 17'h00041, 8'hAB);
    n0 = n_txn;
    cs_low();
    send(8'h80); send(8'h00); send(8'h41); send(8'hAB);
    cs_high();
    chk("post_rst_count", n_txn - n0, 1);
    chk("post_rst_mem", {24'd0, mem[int'(17'h00041)]}, 32'hAB);

    chk("stall_tracks_cyc", stall_bad, 0);
    chk("scoreboard_left", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
